// File: rtl/execute_cycle.sv
// Pipeline EX stage: operand forwarding, ALU, RV32M multiply, iterative divider,
// branch compare and the EX/MEM pipeline register feeding memory_cycle.
module execute_cycle #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter bit          DIV_EN   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_ex_inst,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_rs1_data,
    input  logic [31:0] i_ex_rs2_data,
    input  logic [31:0] i_ex_imm,
    input  logic        i_ex_opa_sel,
    input  logic        i_ex_opb_sel,
    input  logic [3:0]  i_ex_alu_op,
    input  logic        i_ex_md_en,
    input  logic        i_ex_br_un,
    input  logic [1:0]  i_ex_fwd_a_sel,
    input  logic [1:0]  i_ex_fwd_b_sel,
    input  logic [31:0] i_ex_fwd_mem_data,
    input  logic [31:0] i_ex_fwd_wb_data,
    input  logic        i_ex_lsu_wren,
    input  logic [2:0]  i_ex_slt_sl,
    input  logic [1:0]  i_ex_wb_sel,
    input  logic        i_ex_rd_wren,
    input  logic        i_ex_flush,
    output logic        o_ex_stall,
    output logic [31:0] o_ex_inst_mem,
    output logic [31:0] o_ex_pc_mem,
    output logic [31:0] o_ex_rs2_data_mem,
    output logic [31:0] o_ex_alu_data_mem,
    output logic        o_ex_br_equal_mem,
    output logic        o_ex_br_less_mem,
    output logic        o_ex_lsu_wren_mem,
    output logic        o_ex_rd_wren_mem,
    output logic [2:0]  o_ex_slt_sl_mem,
    output logic [1:0]  o_ex_wb_sel_mem,
    output logic [4:0]  o_ex_rd_addr_fwd
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_e;

    div_state_e state, state_nxt;

    logic [2:0]      funct3;
    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b;
    logic [XLEN-1:0] alu_res, mul_res, div_res, ex_result;
    logic            br_equal, br_less;
    logic            is_div, div_start, div_signed;

    // divider state
    logic [XLEN-1:0]  div_quo, div_rem, div_dvsr;
    logic [CNT_W-1:0] div_count;
    logic             div_neg_q, div_neg_r, div_is_rem, div_zero;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic [XLEN:0]    rem_shift;
    logic             rem_ge;
    logic [XLEN-1:0]  rem_sub;

    assign funct3           = i_ex_inst[14:12];
    assign o_ex_rd_addr_fwd = i_ex_inst[11:7];

    // forwarding and operand selection
    always_comb begin
        case (i_ex_fwd_a_sel)
            2'b01:   fwd_a = i_ex_fwd_mem_data;
            2'b10:   fwd_a = i_ex_fwd_wb_data;
            default: fwd_a = i_ex_rs1_data;
        endcase
        case (i_ex_fwd_b_sel)
            2'b01:   fwd_b = i_ex_fwd_mem_data;
            2'b10:   fwd_b = i_ex_fwd_wb_data;
            default: fwd_b = i_ex_rs2_data;
        endcase
        op_a = i_ex_opa_sel ? i_ex_pc  : fwd_a;
        op_b = i_ex_opb_sel ? i_ex_imm : fwd_b;
    end

    always_comb begin
        alu_res = '0;
        case (i_ex_alu_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << op_b[4:0];
            4'd3:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd4:    alu_res = {31'd0, op_a < op_b};
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> op_b[4:0];
            4'd7:    alu_res = 32'($signed(op_a) >>> op_b[4:0]);
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_equal = (fwd_a == fwd_b);
        br_less  = i_ex_br_un ? (fwd_a < fwd_b) : ($signed(fwd_a) < $signed(fwd_b));
    end

    // multiply: sign-extend to 64 bits; the low 64 bits of the product are exact
    logic            mul_a_sx, mul_b_sx;
    logic [63:0]     mul_a, mul_b, mul_prod;
    always_comb begin
        mul_a_sx = ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10)) && op_a[31];
        mul_b_sx = (funct3[1:0] == 2'b01) && op_b[31];
        mul_a    = {{32{mul_a_sx}}, op_a};
        mul_b    = {{32{mul_b_sx}}, op_b};
        mul_prod = mul_a * mul_b;
        mul_res  = (funct3[1:0] == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];
    end

    assign is_div     = i_ex_md_en && funct3[2];
    assign div_signed = ~funct3[0];
    assign div_start  = DIV_EN && (state == IDLE) && is_div && !i_ex_flush && !i_reset;

    // divider FSM: next state and stall
    always_comb begin
        state_nxt  = state;
        o_ex_stall = 1'b0;
        case (state)
            IDLE: begin
                if (div_start) begin
                    o_ex_stall = 1'b1;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                o_ex_stall = 1'b1;
                if (i_ex_flush)
                    state_nxt = IDLE;
                else if (div_count == CNT_W'(XLEN - 1))
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // restoring divide step on magnitudes; signs are fixed up on the way out
    always_comb begin
        a_mag     = (div_signed && op_a[31]) ? 32'(-op_a) : op_a;
        b_mag     = (div_signed && op_b[31]) ? 32'(-op_b) : op_b;
        rem_shift = {div_rem, div_quo[XLEN-1]};
        rem_ge    = (rem_shift >= {1'b0, div_dvsr});
        rem_sub   = rem_shift[XLEN-1:0] - div_dvsr;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_quo    <= '0;
            div_rem    <= '0;
            div_dvsr   <= '0;
            div_count  <= '0;
            div_neg_q  <= 1'b0;
            div_neg_r  <= 1'b0;
            div_is_rem <= 1'b0;
            div_zero   <= 1'b0;
        end else if (div_start) begin
            div_quo    <= a_mag;
            div_rem    <= '0;
            div_dvsr   <= b_mag;
            div_count  <= '0;
            div_neg_q  <= div_signed && (op_a[31] ^ op_b[31]);
            div_neg_r  <= div_signed && op_a[31];
            div_is_rem <= funct3[1];
            div_zero   <= (op_b == '0);
        end else if (state == BUSY) begin
            div_quo   <= {div_quo[XLEN-2:0], rem_ge};
            div_rem   <= rem_ge ? rem_sub : rem_shift[XLEN-1:0];
            div_count <= div_count + CNT_W'(1);
        end
    end

    logic [XLEN-1:0] div_q_fix, div_r_fix;
    always_comb begin
        div_q_fix = div_neg_q ? 32'(-div_quo) : div_quo;
        if (div_zero)
            div_q_fix = '1;
        div_r_fix = div_neg_r ? 32'(-div_rem) : div_rem;
        div_res   = div_is_rem ? div_r_fix : div_q_fix;
    end

    always_comb begin
        ex_result = alu_res;
        if (i_ex_md_en)
            ex_result = funct3[2] ? (DIV_EN ? div_res : '0) : mul_res;
    end

    // EX/MEM register: bubble while stalled or flushed
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ex_inst_mem     <= '0;
            o_ex_pc_mem       <= '0;
            o_ex_rs2_data_mem <= '0;
            o_ex_alu_data_mem <= '0;
            o_ex_br_equal_mem <= 1'b0;
            o_ex_br_less_mem  <= 1'b0;
            o_ex_lsu_wren_mem <= 1'b0;
            o_ex_rd_wren_mem  <= 1'b0;
            o_ex_slt_sl_mem   <= '0;
            o_ex_wb_sel_mem   <= '0;
        end else if (o_ex_stall || i_ex_flush) begin
            o_ex_inst_mem     <= NOP_INST;
            o_ex_pc_mem       <= '0;
            o_ex_rs2_data_mem <= '0;
            o_ex_alu_data_mem <= '0;
            o_ex_br_equal_mem <= 1'b0;
            o_ex_br_less_mem  <= 1'b0;
            o_ex_lsu_wren_mem <= 1'b0;
            o_ex_rd_wren_mem  <= 1'b0;
            o_ex_slt_sl_mem   <= '0;
            o_ex_wb_sel_mem   <= '0;
        end else begin
            o_ex_inst_mem     <= i_ex_inst;
            o_ex_pc_mem       <= i_ex_pc;
            o_ex_rs2_data_mem <= fwd_b;
            o_ex_alu_data_mem <= ex_result;
            o_ex_br_equal_mem <= br_equal;
            o_ex_br_less_mem  <= br_less;
            o_ex_lsu_wren_mem <= i_ex_lsu_wren;
            o_ex_rd_wren_mem  <= i_ex_rd_wren;
            o_ex_slt_sl_mem   <= i_ex_slt_sl;
            o_ex_wb_sel_mem   <= i_ex_wb_sel;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle: ALU, forwarding, multiply,
// divider latency/results, flush abort and asynchronous reset.
module tb_execute_cycle;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_ex_inst, i_ex_pc, i_ex_rs1_data, i_ex_rs2_data, i_ex_imm;
    logic        i_ex_opa_sel, i_ex_opb_sel;
    logic [3:0]  i_ex_alu_op;
    logic        i_ex_md_en, i_ex_br_un;
    logic [1:0]  i_ex_fwd_a_sel, i_ex_fwd_b_sel;
    logic [31:0] i_ex_fwd_mem_data, i_ex_fwd_wb_data;
    logic        i_ex_lsu_wren;
    logic [2:0]  i_ex_slt_sl;
    logic [1:0]  i_ex_wb_sel;
    logic        i_ex_rd_wren, i_ex_flush;
    logic        o_ex_stall;
    logic [31:0] o_ex_inst_mem, o_ex_pc_mem, o_ex_rs2_data_mem, o_ex_alu_data_mem;
    logic        o_ex_br_equal_mem, o_ex_br_less_mem, o_ex_lsu_wren_mem, o_ex_rd_wren_mem;
    logic [2:0]  o_ex_slt_sl_mem;
    logic [1:0]  o_ex_wb_sel_mem;
    logic [4:0]  o_ex_rd_addr_fwd;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    execute_cycle dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_ex_inst         (i_ex_inst),
        .i_ex_pc           (i_ex_pc),
        .i_ex_rs1_data     (i_ex_rs1_data),
        .i_ex_rs2_data     (i_ex_rs2_data),
        .i_ex_imm          (i_ex_imm),
        .i_ex_opa_sel      (i_ex_opa_sel),
        .i_ex_opb_sel      (i_ex_opb_sel),
        .i_ex_alu_op       (i_ex_alu_op),
        .i_ex_md_en        (i_ex_md_en),
        .i_ex_br_un        (i_ex_br_un),
        .i_ex_fwd_a_sel    (i_ex_fwd_a_sel),
        .i_ex_fwd_b_sel    (i_ex_fwd_b_sel),
        .i_ex_fwd_mem_data (i_ex_fwd_mem_data),
        .i_ex_fwd_wb_data  (i_ex_fwd_wb_data),
        .i_ex_lsu_wren     (i_ex_lsu_wren),
        .i_ex_slt_sl       (i_ex_slt_sl),
        .i_ex_wb_sel       (i_ex_wb_sel),
        .i_ex_rd_wren      (i_ex_rd_wren),
        .i_ex_flush        (i_ex_flush),
        .o_ex_stall        (o_ex_stall),
        .o_ex_inst_mem     (o_ex_inst_mem),
        .o_ex_pc_mem       (o_ex_pc_mem),
        .o_ex_rs2_data_mem (o_ex_rs2_data_mem),
        .o_ex_alu_data_mem (o_ex_alu_data_mem),
        .o_ex_br_equal_mem (o_ex_br_equal_mem),
        .o_ex_br_less_mem  (o_ex_br_less_mem),
        .o_ex_lsu_wren_mem (o_ex_lsu_wren_mem),
        .o_ex_rd_wren_mem  (o_ex_rd_wren_mem),
        .o_ex_slt_sl_mem   (o_ex_slt_sl_mem),
        .o_ex_wb_sel_mem   (o_ex_wb_sel_mem),
        .o_ex_rd_addr_fwd  (o_ex_rd_addr_fwd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_ex_inst = 32'h0000_0013; i_ex_pc = '0; i_ex_rs1_data = '0; i_ex_rs2_data = '0;
        i_ex_imm = '0; i_ex_opa_sel = 0; i_ex_opb_sel = 0; i_ex_alu_op = '0;
        i_ex_md_en = 0; i_ex_br_un = 0; i_ex_fwd_a_sel = '0; i_ex_fwd_b_sel = '0;
        i_ex_fwd_mem_data = '0; i_ex_fwd_wb_data = '0; i_ex_lsu_wren = 0;
        i_ex_slt_sl = '0; i_ex_wb_sel = '0; i_ex_rd_wren = 0; i_ex_flush = 0;
    endtask

    // register-register op writing rd = x5
    task automatic set_rr(input logic [3:0] op, input logic md, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
        idle_inputs();
        i_ex_inst     = {7'd1, 5'd2, 5'd1, f3, 5'd5, 7'h33};
        i_ex_pc       = 32'h0000_0100;
        i_ex_rs1_data = a;
        i_ex_rs2_data = b;
        i_ex_alu_op   = op;
        i_ex_md_en    = md;
        i_ex_rd_wren  = 1'b1;
    endtask

    task automatic run_div(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        logic [31:0] inst;
        set_rr(4'd0, 1'b1, f3, a, b);
        inst = i_ex_inst;
        #1;
        check({tag, "_stall_entry"}, 32'(o_ex_stall), 32'd1);
        n = 0;
        while (o_ex_stall && n < 40) begin
            tick();
            n++;
            check({tag, "_bubble_inst"}, o_ex_inst_mem, 32'h0000_0013);
            check({tag, "_bubble_rdwr"}, 32'(o_ex_rd_wren_mem), 32'd0);
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'd33);
        tick();
        check({tag, "_result"}, o_ex_alu_data_mem, exp);
        check({tag, "_inst"}, o_ex_inst_mem, inst);
        check({tag, "_rdwr"}, 32'(o_ex_rd_wren_mem), 32'd1);
        idle_inputs();
    endtask

    localparam int NALU = 12;
    localparam logic [3:0]  T_OP [NALU] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                            4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
    localparam logic [31:0] T_A  [NALU] = '{32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                            32'h0000_F0F0, 32'h8000_0000, 32'h8000_0000,
                                            32'h0000_00F0, 32'h0000_00F0, 32'd1, 32'd5, 32'd5};
    localparam logic [31:0] T_B  [NALU] = '{32'd7, 32'd33, 32'd1, 32'd1, 32'h0000_FF00,
                                            32'd4, 32'd4, 32'h0000_000F, 32'h0000_003C,
                                            32'h00AB_C000, 32'd6, 32'd6};
    localparam logic [31:0] T_E  [NALU] = '{32'hFFFF_FFFE, 32'd2, 32'd1, 32'd0, 32'h0000_0FF0,
                                            32'h0800_0000, 32'hF800_0000, 32'h0000_00FF,
                                            32'h0000_0030, 32'h00AB_C000, 32'd0, 32'd0};

    localparam int NMUL = 6;
    localparam logic [2:0]  M_F3 [NMUL] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd3, 3'd1};
    localparam logic [31:0] M_A  [NMUL] = '{32'd3, 32'h8000_0000, 32'h8000_0000,
                                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] M_B  [NMUL] = '{32'hFFFF_FFFC, 32'd2, 32'd2, 32'd2,
                                            32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] M_E  [NMUL] = '{32'hFFFF_FFF4, 32'hFFFF_FFFF, 32'd1,
                                            32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};

    initial begin
        idle_inputs();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_inst", o_ex_inst_mem, 32'd0);
        check("rst_alu", o_ex_alu_data_mem, 32'd0);
        check("rst_stall", 32'(o_ex_stall), 32'd0);
        check("rst_rdwr", 32'(o_ex_rd_wren_mem), 32'd0);
        i_reset = 1'b0;
        tick();

        // ADDI with MEM-forwarded rs1 and WB-forwarded rs2
        idle_inputs();
        i_ex_inst = 32'h0040_8293; i_ex_pc = 32'h0000_0200;
        i_ex_fwd_a_sel = 2'b01; i_ex_fwd_mem_data = 32'h10; i_ex_rs1_data = 32'h999;
        i_ex_opb_sel = 1'b1; i_ex_imm = 32'd4;
        i_ex_fwd_b_sel = 2'b10; i_ex_fwd_wb_data = 32'hABCD; i_ex_rs2_data = 32'h55;
        i_ex_rd_wren = 1'b1; i_ex_wb_sel = 2'b01; i_ex_slt_sl = 3'b010; i_ex_lsu_wren = 1'b1;
        #1;
        check("rd_addr_fwd", 32'(o_ex_rd_addr_fwd), 32'd5);
        tick();
        check("add_fwd_alu", o_ex_alu_data_mem, 32'h14);
        check("add_fwd_rs2", o_ex_rs2_data_mem, 32'hABCD);
        check("add_inst", o_ex_inst_mem, 32'h0040_8293);
        check("add_pc", o_ex_pc_mem, 32'h0000_0200);
        check("add_wbsel", 32'(o_ex_wb_sel_mem), 32'd1);
        check("add_sltsl", 32'(o_ex_slt_sl_mem), 32'd2);
        check("add_lsuwr", 32'(o_ex_lsu_wren_mem), 32'd1);
        check("add_rdwr", 32'(o_ex_rd_wren_mem), 32'd1);

        // pc + imm through operand A select
        idle_inputs();
        i_ex_opa_sel = 1'b1; i_ex_opb_sel = 1'b1; i_ex_pc = 32'h1000; i_ex_imm = 32'h20;
        i_ex_rs1_data = 32'h7777;
        tick();
        check("auipc", o_ex_alu_data_mem, 32'h1020);

        for (int i = 0; i < NALU; i++) begin
            set_rr(T_OP[i], 1'b0, 3'd0, T_A[i], T_B[i]);
            tick();
            check($sformatf("alu_op%0d", T_OP[i]), o_ex_alu_data_mem, T_E[i]);
        end

        for (int i = 0; i < NMUL; i++) begin
            set_rr(4'd0, 1'b1, M_F3[i], M_A[i], M_B[i]);
            tick();
            check($sformatf("mul_f3_%0d_v%0d", M_F3[i], i), o_ex_alu_data_mem, M_E[i]);
        end

        // branch compares
        set_rr(4'd0, 1'b0, 3'd0, 32'd5, 32'd5);
        tick();
        check("beq_equal", 32'(o_ex_br_equal_mem), 32'd1);
        set_rr(4'd0, 1'b0, 3'd6, 32'd1, 32'hFFFF_FFFF);
        i_ex_br_un = 1'b1;
        tick();
        check("bltu_less", 32'(o_ex_br_less_mem), 32'd1);
        check("bltu_equal", 32'(o_ex_br_equal_mem), 32'd0);
        set_rr(4'd0, 1'b0, 3'd4, 32'd1, 32'hFFFF_FFFF);
        tick();
        check("blt_less", 32'(o_ex_br_less_mem), 32'd0);

        run_div("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("divu_100_0", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_div("remu_100_0", 3'd7, 32'd100, 32'd0, 32'd100);
        run_div("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div("divu_big", 3'd5, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
        run_div("rem_m7_0", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

        // flush during the 10th BUSY cycle aborts the divide
        set_rr(4'd0, 1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2);
        #1;
        repeat (10) tick();
        i_ex_flush = 1'b1;
        #1;
        check("flush_busy_stall", 32'(o_ex_stall), 32'd1);
        tick();
        check("flush_inst", o_ex_inst_mem, 32'h0000_0013);
        check("flush_rdwr", 32'(o_ex_rd_wren_mem), 32'd0);
        set_rr(4'd0, 1'b0, 3'd0, 32'd1, 32'd1);
        #1;
        check("flush_stall_drop", 32'(o_ex_stall), 32'd0);
        tick();
        check("post_flush_add", o_ex_alu_data_mem, 32'd2);

        // asynchronous reset in the middle of a divide
        set_rr(4'd0, 1'b1, 3'd4, 32'd100, 32'd7);
        #1;
        repeat (5) tick();
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_inst", o_ex_inst_mem, 32'd0);
        check("arst_alu", o_ex_alu_data_mem, 32'd0);
        check("arst_stall", 32'(o_ex_stall), 32'd0);
        check("arst_wbsel", 32'(o_ex_wb_sel_mem), 32'd0);
        idle_inputs();
        tick();
        tick();
        i_reset = 1'b0;
        #1;
        check("arst_release_stall", 32'(o_ex_stall), 32'd0);
        set_rr(4'd0, 1'b0, 3'd0, 32'd1, 32'd1);
        #1;
        check("arst_add_nostall", 32'(o_ex_stall), 32'd0);
        tick();
        check("arst_add", o_ex_alu_data_mem, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
